// File: rtl/leitor_vga_quadro.sv
// VGA scan-out of a centred stored frame: timing counters, running RAM address,
// and a two-tick pipeline that keeps syncs aligned with the fetched pixel.
module leitor_vga_quadro #(
    parameter int H_ATIVO  = 640,
    parameter int H_FRENTE = 16,
    parameter int H_SINC   = 96,
    parameter int H_TRAS   = 48,
    parameter int V_ATIVO  = 480,
    parameter int V_FRENTE = 10,
    parameter int V_SINC   = 2,
    parameter int V_TRAS   = 33,
    parameter int IMG_LARG = 320,
    parameter int IMG_ALT  = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pixel_en,
    input  logic              banco_sel,
    output logic              banco_ativo,
    output logic [ADDR_W-1:0] endereco,
    output logic              rden,
    input  logic [7:0]        q_a,
    input  logic [7:0]        q_b,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              hsync,
    output logic              vsync,
    output logic              blank_n,
    output logic              quadro_inicio
);
    localparam int H_TOTAL = H_ATIVO + H_FRENTE + H_SINC + H_TRAS;
    localparam int V_TOTAL = V_ATIVO + V_FRENTE + V_SINC + V_TRAS;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int OFF_X   = (H_ATIVO - IMG_LARG) / 2;
    localparam int OFF_Y   = (V_ATIVO - IMG_ALT) / 2;

    localparam logic [HW-1:0] H_ULT  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HA_ULT = HW'(H_ATIVO - 1);
    localparam logic [HW-1:0] HS_INI = HW'(H_ATIVO + H_FRENTE);
    localparam logic [HW-1:0] HS_FIM = HW'(H_ATIVO + H_FRENTE + H_SINC - 1);
    localparam logic [HW-1:0] JX_INI = HW'(OFF_X);
    localparam logic [HW-1:0] JX_FIM = HW'(OFF_X + IMG_LARG - 1);
    localparam logic [VW-1:0] V_ULT  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VA_ULT = VW'(V_ATIVO - 1);
    localparam logic [VW-1:0] VS_INI = VW'(V_ATIVO + V_FRENTE);
    localparam logic [VW-1:0] VS_FIM = VW'(V_ATIVO + V_FRENTE + V_SINC - 1);
    localparam logic [VW-1:0] JY_INI = VW'(OFF_Y);
    localparam logic [VW-1:0] JY_FIM = VW'(OFF_Y + IMG_ALT - 1);

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic              prim_q;
    logic [ADDR_W-1:0] prox_q;
    logic [ADDR_W-1:0] end_q;
    logic              rden_q, banco_q, qi_q;
    logic [1:0]        hs_pipe_q, vs_pipe_q, bl_pipe_q;
    logic              hs_q, vs_q, bl_q;
    logic [7:0]        pix_q, rgb_q;
    logic              janela_d, inicio_d, hs_d, vs_d, bl_d;

    // prim_q makes the first tick after reset land on (0,0) rather than skip it
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!prim_q) begin
            if (h_q == H_ULT) begin
                h_d = '0;
                v_d = (v_q == V_ULT) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        inicio_d = (h_d == '0) && (v_d == '0);
        janela_d = (h_d >= JX_INI) && (h_d <= JX_FIM) && (v_d >= JY_INI) && (v_d <= JY_FIM);
        hs_d     = !((h_d >= HS_INI) && (h_d <= HS_FIM));
        vs_d     = !((v_d >= VS_INI) && (v_d <= VS_FIM));
        bl_d     = (h_d <= HA_ULT) && (v_d <= VA_ULT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_q       <= '0;
            v_q       <= '0;
            prim_q    <= 1'b1;
            prox_q    <= '0;
            end_q     <= '0;
            rden_q    <= 1'b0;
            banco_q   <= 1'b0;
            hs_pipe_q <= 2'b11;
            vs_pipe_q <= 2'b11;
            bl_pipe_q <= 2'b00;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            bl_q      <= 1'b0;
            pix_q     <= 8'h00;
            rgb_q     <= 8'h00;
        end else if (pixel_en) begin
            prim_q <= 1'b0;
            h_q    <= h_d;
            v_q    <= v_d;
            rden_q <= janela_d;
            if (inicio_d) begin
                end_q   <= '0;
                prox_q  <= '0;
                banco_q <= banco_sel;
            end else if (janela_d) begin
                end_q  <= prox_q;
                prox_q <= prox_q + 1'b1;
            end
            // RAM data for the previous position has settled by this tick
            pix_q     <= rden_q ? (banco_q ? q_b : q_a) : 8'h00;
            rgb_q     <= pix_q;
            hs_pipe_q <= {hs_pipe_q[0], hs_d};
            vs_pipe_q <= {vs_pipe_q[0], vs_d};
            bl_pipe_q <= {bl_pipe_q[0], bl_d};
            hs_q      <= hs_pipe_q[1];
            vs_q      <= vs_pipe_q[1];
            bl_q      <= bl_pipe_q[1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) qi_q <= 1'b0;
        else          qi_q <= pixel_en && inicio_d;
    end

    assign banco_ativo   = banco_q;
    assign endereco      = end_q;
    assign rden          = rden_q;
    assign vga_r         = rgb_q;
    assign vga_g         = rgb_q;
    assign vga_b         = rgb_q;
    assign hsync         = hs_q;
    assign vsync         = vs_q;
    assign blank_n       = bl_q;
    assign quadro_inicio = qi_q;
endmodule

// File: tb/tb_leitor_vga_quadro.sv
// Bench for leitor_vga_quadro on a shrunken raster (30x20 total, 10x6 image)
// so whole frames fit in a short run; expectations come from raster arithmetic.
module tb_leitor_vga_quadro;
    localparam int HA = 20, HF = 3, HSW = 4, HB = 3, HT = HA + HF + HSW + HB;
    localparam int VA = 14, VF = 2, VSW = 2, VB = 2, VT = VA + VF + VSW + VB;
    localparam int IL = 10, IA = 6, AW = 6;
    localparam int OX = (HA - IL) / 2, OY = (VA - IA) / 2;
    localparam int NPIX = IL * IA;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          pixel_en = 1'b0;
    logic          banco_sel = 1'b0;
    logic          banco_ativo;
    logic [AW-1:0] endereco;
    logic          rden;
    logic [7:0]    q_a = 8'h00, q_b = 8'h00;
    logic [7:0]    vga_r, vga_g, vga_b;
    logic          hsync, vsync, blank_n, quadro_inicio;

    leitor_vga_quadro #(
        .H_ATIVO(HA), .H_FRENTE(HF), .H_SINC(HSW), .H_TRAS(HB),
        .V_ATIVO(VA), .V_FRENTE(VF), .V_SINC(VSW), .V_TRAS(VB),
        .IMG_LARG(IL), .IMG_ALT(IA), .ADDR_W(AW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .pixel_en(pixel_en), .banco_sel(banco_sel),
        .banco_ativo(banco_ativo), .endereco(endereco), .rden(rden),
        .q_a(q_a), .q_b(q_b), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .quadro_inicio(quadro_inicio)
    );

    always #5 clock = ~clock;

    logic [7:0] mem_a [0:(1<<AW)-1];
    logic [7:0] mem_b [0:(1<<AW)-1];

    // Synchronous-read RAM pair with one clock of latency
    always @(posedge clock) begin
        if (rden) begin
            q_a <= mem_a[endereco];
            q_b <= mem_b[endereco];
        end
    end

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       bl;
        logic [7:0] rgb;
    } tup_t;

    tup_t          hist[$];
    int            n_ticks;
    int            cur_h, cur_v;
    logic          m_bank;
    logic [AW-1:0] e_addr;
    logic          e_rden, e_bank, e_qi;
    tup_t          e_out;
    int            n_chk = 0, n_pass = 0, n_fail = 0;

    function automatic logic in_win(input int h, input int v);
        return h >= OX && h < OX + IL && v >= OY && v < OY + IA;
    endfunction

    task automatic mdl_reset;
        tup_t r;
        r = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, rgb: 8'h00};
        n_ticks = 0;
        m_bank  = 1'b0;
        e_addr  = '0;
        e_rden  = 1'b0;
        e_bank  = 1'b0;
        e_qi    = 1'b0;
        e_out   = r;
        hist.delete();
        hist.push_back(r);
        hist.push_back(r);
    endtask

    // One pixel tick after (gap-2) idle clocks; the model advances with it.
    task automatic tick(input int gap);
        int   idx;
        logic w;
        tup_t t;
        repeat (gap - 2) @(negedge clock);
        @(negedge clock);
        pixel_en = 1'b1;
        idx   = n_ticks;
        n_ticks++;
        cur_h = idx % HT;
        cur_v = (idx / HT) % VT;
        w     = in_win(cur_h, cur_v);
        e_qi  = (cur_h == 0 && cur_v == 0);
        if (e_qi) begin
            m_bank = banco_sel;
            e_addr = '0;
        end
        if (w) e_addr = AW'((cur_v - OY) * IL + (cur_h - OX));
        e_rden = w;
        e_bank = m_bank;
        t.hs  = !(cur_h >= HA + HF && cur_h < HA + HF + HSW);
        t.vs  = !(cur_v >= VA + VF && cur_v < VA + VF + VSW);
        t.bl  = cur_h < HA && cur_v < VA;
        t.rgb = w ? (m_bank ? mem_b[e_addr] : mem_a[e_addr]) : 8'h00;
        hist.push_back(t);
        e_out = hist.pop_front();
        @(negedge clock);
        pixel_en = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clock);
        #2 reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        mdl_reset();
    endtask

    task automatic test_reset;
        int hs_low, vs_low;
        banco_sel = 1'b1;
        for (int i = 0; i < 37; i++) tick(2 + $urandom_range(0, 2));
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_chk++;
        if ({hsync, vsync, blank_n, quadro_inicio} !== 4'b1100) begin
            n_fail++; $display("FAIL reset_sync got=%b want=1100", {hsync, vsync, blank_n, quadro_inicio});
        end else n_pass++;
        n_chk++;
        if ({vga_r, vga_g, vga_b} !== 24'h0) begin
            n_fail++; $display("FAIL reset_rgb got=%h want=0", {vga_r, vga_g, vga_b});
        end else n_pass++;
        n_chk++;
        if ({rden, banco_ativo, endereco} !== '0) begin
            n_fail++; $display("FAIL reset_addr got rden=%b bank=%b addr=%0d want 0", rden, banco_ativo, endereco);
        end else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        mdl_reset();
        hs_low = 0;
        vs_low = 0;
        for (int n = 0; n < 2 * HT * VT + 2; n++) begin
            tick(2);
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
        end
        n_chk++;
        if (hs_low !== 2 * VT * HSW) begin
            n_fail++; $display("FAIL hsync_low_ticks got=%0d want=%0d", hs_low, 2 * VT * HSW);
        end else n_pass++;
        n_chk++;
        if (vs_low !== 2 * VSW * HT) begin
            n_fail++; $display("FAIL vsync_low_ticks got=%0d want=%0d", vs_low, 2 * VSW * HT);
        end else n_pass++;
    endtask

    task automatic test_random_stream;
        do_reset();
        banco_sel = 1'($urandom_range(0, 1));
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 39) == 0) banco_sel = ~banco_sel;
            tick(2 + $urandom_range(0, 3));
            n_chk++;
            if ({hsync, vsync, blank_n, vga_r} !== e_out) begin
                n_fail++; $display("FAIL stream_out t=%0d got=%h want=%h", n_ticks, {hsync, vsync, blank_n, vga_r}, e_out);
            end else n_pass++;
            n_chk++;
            if (vga_g !== vga_r || vga_b !== vga_r) begin
                n_fail++; $display("FAIL stream_gray t=%0d got r=%h g=%h b=%h", n_ticks, vga_r, vga_g, vga_b);
            end else n_pass++;
            n_chk++;
            if ({rden, endereco, banco_ativo, quadro_inicio} !== {e_rden, e_addr, e_bank, e_qi}) begin
                n_fail++; $display("FAIL stream_fetch t=%0d got=%h want=%h", n_ticks,
                                   {rden, endereco, banco_ativo, quadro_inicio}, {e_rden, e_addr, e_bank, e_qi});
            end else n_pass++;
            if (e_qi) begin
                @(negedge clock);
                n_chk++;
                if (quadro_inicio !== 1'b0) begin
                    n_fail++; $display("FAIL stream_qi_width got=%b want=0", quadro_inicio);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_window_start;
        do_reset();
        banco_sel = 1'b0;
        repeat (OY * HT + OX + 1) tick(2);
        n_chk++;
        if ({rden, endereco} !== {1'b1, AW'(0)}) begin
            n_fail++; $display("FAIL win_first_addr got rden=%b addr=%0d want 1/0", rden, endereco);
        end else n_pass++;
        tick(2);
        n_chk++;
        if (endereco !== AW'(1)) begin
            n_fail++; $display("FAIL win_second_addr got=%0d want=1", endereco);
        end else n_pass++;
        tick(2);
        n_chk++;
        if ({blank_n, vga_r} !== {1'b1, 8'h00}) begin
            n_fail++; $display("FAIL win_first_rgb got bl=%b rgb=%h want 1/00", blank_n, vga_r);
        end else n_pass++;
        tick(2);
        n_chk++;
        if (vga_r !== 8'h01) begin
            n_fail++; $display("FAIL win_second_rgb got=%h want=01", vga_r);
        end else n_pass++;
    endtask

    task automatic test_full_frame;
        int cnt, maxa, last_h, last_v, bad;
        do_reset();
        banco_sel = 1'b0;
        cnt = 0; maxa = 0; last_h = -1; last_v = -1; bad = 0;
        for (int n = 1; n <= HT * VT + 2; n++) begin
            tick(2);
            if (rden) begin
                cnt++;
                if (endereco == AW'(NPIX - 1)) begin
                    last_h = (n - 1) % HT;
                    last_v = (n - 1) / HT;
                end
            end
            if (int'(endereco) > maxa) maxa = int'(endereco);
            if (n >= 3 && blank_n && !in_win((n - 3) % HT, ((n - 3) / HT) % VT) && vga_r !== 8'h00) bad++;
        end
        n_chk++;
        if (cnt !== NPIX) begin
            n_fail++; $display("FAIL frame_rden_ticks got=%0d want=%0d", cnt, NPIX);
        end else n_pass++;
        n_chk++;
        if (maxa !== NPIX - 1) begin
            n_fail++; $display("FAIL frame_max_addr got=%0d want=%0d", maxa, NPIX - 1);
        end else n_pass++;
        n_chk++;
        if (last_h !== OX + IL - 1 || last_v !== OY + IA - 1) begin
            n_fail++; $display("FAIL frame_last_pos got=(%0d,%0d) want=(%0d,%0d)", last_h, last_v, OX + IL - 1, OY + IA - 1);
        end else n_pass++;
        n_chk++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL frame_border_black got=%0d nonzero pixels want=0", bad);
        end else n_pass++;
    endtask

    task automatic test_bank_switch;
        do_reset();
        banco_sel = 1'b0;
        repeat (10 * HT) tick(2);
        banco_sel = 1'b1;
        for (int n = 10 * HT; n < HT * VT; n++) begin
            tick(2);
            n_chk++;
            if ({banco_ativo, quadro_inicio} !== 2'b00) begin
                n_fail++; $display("FAIL bank_hold t=%0d got bank=%b qi=%b want 0/0", n + 1, banco_ativo, quadro_inicio);
            end else n_pass++;
        end
        tick(2);
        n_chk++;
        if ({banco_ativo, quadro_inicio} !== 2'b11) begin
            n_fail++; $display("FAIL bank_latch got bank=%b qi=%b want 1/1", banco_ativo, quadro_inicio);
        end else n_pass++;
        @(negedge clock);
        n_chk++;
        if (quadro_inicio !== 1'b0) begin
            n_fail++; $display("FAIL bank_qi_pulse got=%b want=0", quadro_inicio);
        end else n_pass++;
        banco_sel = 1'b0;
        repeat (OY * HT + OX + 2) tick(2);
        n_chk++;
        if ({banco_ativo, vga_r} !== {1'b1, mem_b[0]}) begin
            n_fail++; $display("FAIL bank_b_pix0 got bank=%b rgb=%h want 1/%h", banco_ativo, vga_r, mem_b[0]);
        end else n_pass++;
        tick(2);
        n_chk++;
        if (vga_r !== mem_b[1]) begin
            n_fail++; $display("FAIL bank_b_pix1 got=%h want=%h", vga_r, mem_b[1]);
        end else n_pass++;
    endtask

    task automatic test_freeze;
        do_reset();
        banco_sel = 1'b0;
        repeat ((OY + 1) * HT + OX + 3 + 1) tick(2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_chk++;
            if ({endereco, rden, vga_r, hsync, vsync, blank_n} !== {AW'(IL + 3), 1'b1, 8'(IL + 1), 3'b111}) begin
                n_fail++; $display("FAIL freeze_hold clk=%0d got addr=%0d rden=%b rgb=%h sync=%b%b%b",
                                   i, endereco, rden, vga_r, hsync, vsync, blank_n);
            end else n_pass++;
        end
        tick(2);
        n_chk++;
        if ({endereco, vga_r} !== {AW'(IL + 4), 8'(IL + 2)}) begin
            n_fail++; $display("FAIL freeze_resume got addr=%0d rgb=%h want %0d/%h", endereco, vga_r, IL + 4, IL + 2);
        end else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] rec2 [0:139];
        logic [7:0] rec4 [0:139];
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            banco_sel = 1'b1;
            for (int n = 0; n < 140; n++) begin
                tick(pass == 0 ? 2 : 4);
                if (pass == 0) rec2[n] = vga_r;
                else           rec4[n] = vga_r;
            end
        end
        for (int n = 0; n < 140; n++) begin
            n_chk++;
            if (rec4[n] !== rec2[n]) begin
                n_fail++; $display("FAIL gap_equal t=%0d got=%h want=%h", n + 1, rec4[n], rec2[n]);
            end else n_pass++;
        end
        for (int i = 0; i < IL; i++) begin
            n_chk++;
            if (rec2[OY * HT + OX + 2 + i] !== mem_b[i]) begin
                n_fail++; $display("FAIL gap_row0 i=%0d got=%h want=%h", i, rec2[OY * HT + OX + 2 + i], mem_b[i]);
            end else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired after %0d checks", n_chk);
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < (1 << AW); k++) begin
            mem_a[k] = 8'(k);
            mem_b[k] = 8'($urandom_range(0, 255));
        end
        mdl_reset();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        test_reset();
        test_window_start();
        test_full_frame();
        test_bank_switch();
        test_freeze();
        test_random_stream();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/leitor_vga_quadro.md
Name: leitor_vga_quadro

Overview:
Downstream display stage for the pixel-replication zoom. It generates 640x480@60 Hz VGA timing and fetches 8-bit grayscale pixels from whichever processed-image RAM bank currently holds the finished frame. It centres the stored image in the active area and drives black outside it. Bank selection is latched only at frame boundaries, so the zoom engine can swap banks without tearing.

Parameters:
H_ATIVO, 640, active pixels per line
H_FRENTE, 16, horizontal front porch
H_SINC, 96, hsync pulse width
H_TRAS, 48, horizontal back porch (line total 800)
V_ATIVO, 480, active lines
V_FRENTE, 10, vertical front porch
V_SINC, 2, vsync pulse width
V_TRAS, 33, vertical back porch (frame total 525)
IMG_LARG, 320, stored image width in pixels
IMG_ALT, 240, stored image height in lines
ADDR_W, 17, RAM address width; must satisfy IMG_LARG*IMG_ALT <= 2^ADDR_W

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pixel_en  in  1  pixel-rate tick (25 MHz equivalent); all counters and pipeline stages advance only when it is high; consecutive ticks are at least 2 clocks apart
banco_sel  in  1  bank holding the finished image (0 = A, 1 = B)
banco_ativo  out  1  bank being displayed this frame
endereco  out  ADDR_W  read address to both RAMs
rden  out  1  read enable (high while fetching an in-window pixel)
q_a  in  8  bank A read data, 1-clock latency
q_b  in  8  bank B read data, 1-clock latency
vga_r / vga_g / vga_b  out  8 each  grayscale pixel (all three equal)
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
blank_n  out  1  high during the active area
quadro_inicio  out  1  one-clock pulse at each frame start

Behaviour:
- Reset (async, any time): h=0, v=0, pipeline flushed. Outputs: hsync=1, vsync=1, blank_n=0, rgb=0, endereco=0, rden=0, banco_ativo=0, quadro_inicio=0.
- Counters, on pixel_en only:
  - h runs 0..799 and wraps to 0.
  - v increments when h wraps; v runs 0..524 and wraps to 0.
- Window: OFF_X=(H_ATIVO-IMG_LARG)/2=160, OFF_Y=(V_ATIVO-IMG_ALT)/2=120. A pixel is in-window when OFF_X<=h<OFF_X+IMG_LARG and OFF_Y<=v<OFF_Y+IMG_ALT.
- Address generation: endereco=(v-OFF_Y)*IMG_LARG+(h-OFF_X). It is implemented as a running counter, not a multiplier:
  - cleared to 0 at frame start;
  - incremented once per in-window pixel_en;
  - held between window pixels.
  - First window pixel reads address 0. The last reads IMG_LARG*IMG_ALT-1 (76799).
- Pipeline stage 0 (counter position P): drive endereco and rden=in_window(P) in the same clock the counters move to P.
- Pipeline stage 1: q is valid 1 clock later and is sampled at the next pixel_en.
- Output stage (2 pixel_en ticks after P):
  - rgb=banco_ativo ? q_b : q_a when in_window(P), else 0.
  - hsync, vsync and blank_n for P are delayed through the same 2 stages, so they stay aligned with rgb.
- Sync timing for counter position P:
  - hsync low for 656<=h<=751.
  - vsync low for 490<=v<=491.
  - blank_n high for h<640 and v<480.
  - All three appear on the outputs 2 ticks later.
- Bank latch: on the pixel_en at which the counters move to (0,0), including the first tick after reset, banco_ativo<=banco_sel. banco_sel changes at any other time are ignored until the next frame start.
- quadro_inicio: single-clock pulse coincident with the bank latch.
- pixel_en held low: everything freezes, all outputs hold, endereco is stable.
- Mid-frame reset: the next frame starts at (0,0). There is no partial-frame recovery; the address restarts at 0.

Test Plan:
1. Assert reset_n=0 mid-run -> immediately hsync=1, vsync=1, blank_n=0, rgb=0, rden=0, endereco=0. Release it, then count pixel_en ticks -> hsync low for 96 ticks every 800; vsync low for 2 lines every 525.
2. Preload bank A with data[k]=k[7:0], banco_sel=0, advance to h=160, v=120 -> endereco=0 and rden=1 at that tick. rgb=8'h00 and blank_n=1 two ticks later. At h=161, rgb=8'h01 two ticks later.
3. Run a full frame -> rden is high exactly 76800 ticks. Last address is 76799 at h=479, v=359. endereco never exceeds 76799. rgb=0 outside the window with blank_n=1.
4. Toggle banco_sel to 1 at v=200 -> banco_ativo stays 0 for the rest of the frame. banco_ativo becomes 1 with quadro_inicio pulse at the next (0,0). rgb then follows q_b.
5. Hold pixel_en low for 10 clocks inside the window -> endereco, rgb and syncs unchanged. Resuming continues with the next sequential address, with no skip or repeat.
6. pixel_en every 2 clocks vs every 4 clocks -> identical rgb sequence, demonstrating the 1-clock RAM latency is absorbed.
